hazard_scoreboard: RTL

//  Parametrised successor to the decode-stage stall logic: tracks load-use and multdiv RAW/WAW hazards

---
 rtl/hazard_scoreboard.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: load-use and multdiv RAW/WAW/structural stalls
// with a single-entry multdiv busy tracker, watchdog and stall counter.
module hazard_scoreboard #(
   parameter  int NREG      = 32,
   parameter  int MD_MAXCYC = 40,
   parameter  int CNT_W     = 16,
   localparam int RW        = $clog2(NREG)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [31:0]      fd_insn,
   input  logic [31:0]      dx_insn,
   input  logic             md_issue,
   input  logic             md_done,
   input  logic             flush,
   output logic             stall,
   output logic             md_busy,
   output logic [RW-1:0]    md_dest,
   output logic             md_timeout,
   output logic [CNT_W-1:0] stall_count
);

   localparam int WD_W = $clog2(MD_MAXCYC + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(MD_MAXCYC);

   localparam logic [4:0] OP_ALU  = 5'b00000;
   localparam logic [4:0] OP_J    = 5'b00001;
   localparam logic [4:0] OP_BNE  = 5'b00010;
   localparam logic [4:0] OP_JAL  = 5'b00011;
   localparam logic [4:0] OP_JR   = 5'b00100;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_BLT  = 5'b00110;
   localparam logic [4:0] OP_SW   = 5'b00111;
   localparam logic [4:0] OP_LW   = 5'b01000;
   localparam logic [4:0] OP_SETX = 5'b10101;
   localparam logic [4:0] OP_BEX  = 5'b10110;

   localparam logic [4:0] ALU_SLL = 5'b00100;
   localparam logic [4:0] ALU_SRA = 5'b00101;
   localparam logic [4:0] ALU_MUL = 5'b00110;
   localparam logic [4:0] ALU_DIV = 5'b00111;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state_q, state_d;
   logic [RW-1:0]    md_dest_q, md_dest_d;
   logic [WD_W-1:0]  wd_q, wd_d;
   logic             md_timeout_q, md_timeout_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;

   // Narrow a 5-bit field to RW bits, keeping the upper bits
   function automatic logic [RW-1:0] ridx(input logic [4:0] f);
      return f[4 -: RW];
   endfunction

   function automatic logic reads_reg(input logic [31:0] i,
                                      input logic [RW-1:0] r);
      logic [4:0] op, alu;
      logic       use_rs, use_rt, use_rd, use_30;
      op     = i[31:27];
      alu    = i[6:2];
      use_rs = !(op == OP_J || op == OP_JAL ||
                 op == OP_SETX || op == OP_BEX);
      use_rt = (op == OP_ALU) && alu != ALU_SLL && alu != ALU_SRA;
      use_rd = op == OP_SW || op == OP_BNE ||
               op == OP_BLT || op == OP_JR;
      use_30 = op == OP_BEX;
      return (r != '0) &&
             ((use_rs && ridx(i[21:17]) == r) ||
              (use_rt && ridx(i[16:12]) == r) ||
              (use_rd && ridx(i[26:22]) == r) ||
              (use_30 && ridx(5'd30) == r));
   endfunction

   function automatic logic writes_reg(input logic [31:0] i,
                                       input logic [RW-1:0] r);
      logic [4:0] op;
      op = i[31:27];
      return (r != '0) &&
             (((op == OP_ALU || op == OP_ADDI || op == OP_LW) &&
               ridx(i[26:22]) == r) ||
              (op == OP_JAL  && ridx(5'd31) == r) ||
              (op == OP_SETX && ridx(5'd30) == r));
   endfunction

   logic [RW-1:0] dx_rd;
   logic          dx_is_lw, fd_is_md, issue_ok;
   logic          load_use, md_raw, md_waw, md_struct;
   logic          unused_bits;

   assign dx_rd    = ridx(dx_insn[26:22]);
   assign dx_is_lw = dx_insn[31:27] == OP_LW;
   assign fd_is_md = fd_insn[31:27] == OP_ALU &&
                     (fd_insn[6:2] == ALU_MUL || fd_insn[6:2] == ALU_DIV);
   assign issue_ok = md_issue && !flush;

   assign load_use  = dx_is_lw && dx_rd != '0 && reads_reg(fd_insn, dx_rd);
   assign md_raw    = md_busy && reads_reg(fd_insn, md_dest_q);
   assign md_waw    = md_busy && writes_reg(fd_insn, md_dest_q);
   assign md_struct = md_busy && !md_done && fd_is_md;
   assign stall     = load_use | md_raw | md_waw | md_struct;

   assign unused_bits = ^{dx_insn[21:0], fd_insn[11:7], fd_insn[1:0]};

   always_comb begin
      state_d       = state_q;
      md_dest_d     = md_dest_q;
      wd_d          = wd_q;
      md_timeout_d  = md_timeout_q;
      stall_count_d = stall_count_q;
      unique case (state_q)
         IDLE: begin
            if (issue_ok) begin
               state_d   = BUSY;
               md_dest_d = dx_rd;
               wd_d      = '0;
            end
         end
         BUSY: begin
            if (md_done) begin
               wd_d = '0;
               if (issue_ok) begin
                  md_dest_d = dx_rd;
               end else begin
                  state_d   = IDLE;
                  md_dest_d = '0;
               end
            end else if (wd_q != WD_MAX) begin
               wd_d = wd_q + 1'b1;
               if (wd_d == WD_MAX) md_timeout_d = 1'b1;
            end
         end
         default: begin
            state_d   = IDLE;
            md_dest_d = '0;
            wd_d      = '0;
         end
      endcase
      if (stall && !(&stall_count_q))
         stall_count_d = stall_count_q + 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         md_dest_q     <= '0;
         wd_q          <= '0;
         md_timeout_q  <= 1'b0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         md_dest_q     <= md_dest_d;
         wd_q          <= wd_d;
         md_timeout_q  <= md_timeout_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign md_busy     = state_q == BUSY;
   assign md_dest     = md_dest_q;
   assign md_timeout  = md_timeout_q;
   assign stall_count = stall_count_q;

endmodule
